tcs_freq_sampler: RTL and testbench

Front-end capture stage for the TCS3200 colour sensor. It synchronises the asynchronous sensor_out pulse train and drives the S2/S3 filter select. For each filter (red, green, blue, clear) it waits a settle time, then counts sensor_out rising edges over a fixed gate window. It publishes the four raw counts as one coherent frame, with a one-cycle valid pulse, to the downstream normalisation stage.

---
 rtl/tcs_freq_sampler.sv | 177 +++++++++++++++++
 tb/tb_tcs_freq_sampler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcs_freq_sampler.sv
// TCS3200 capture stage: filter sequencing, edge counting
// and frame publication of raw R/G/B/C frequency counts.
module tcs_freq_sampler #(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_out,
  input  logic             start,
  input  logic             continuous,
  output logic [1:0]       s2_s3,
  output logic [CNT_W-1:0] freq_red,
  output logic [CNT_W-1:0] freq_green,
  output logic [CNT_W-1:0] freq_blue,
  output logic [CNT_W-1:0] freq_clear,
  output logic             sample_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW =
    (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST =
    GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       chan_q;
  logic [SW-1:0]    settle_cnt;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] shadow_q [0:3];
  logic             frame_ovf;
  logic             sync1;
  logic             sync2;
  logic             prev;

  logic             edge_pulse;
  logic             settle_done;
  logic             gate_done;
  logic             cnt_hit;
  logic             ovf_now;
  logic [CNT_W-1:0] cnt_next;

  function automatic logic [1:0] sel_of(
    input logic [1:0] ch
  );
    logic [1:0] s;
    unique case (ch)
      2'd0:    s = 2'b00;
      2'd1:    s = 2'b11;
      2'd2:    s = 2'b01;
      default: s = 2'b10;
    endcase
    return s;
  endfunction

  assign edge_pulse  = sync2 & ~prev;
  assign settle_done = (state_q == SETTLE) &&
                       (settle_cnt == SETTLE_LAST);
  assign gate_done   = (state_q == MEASURE) &&
                       (gate_cnt == GATE_LAST);
  assign cnt_hit     = (state_q == MEASURE) && edge_pulse;
  assign ovf_now     = cnt_hit && (edge_cnt == CNT_MAX);
  assign cnt_next    = (cnt_hit && !ovf_now) ?
                       edge_cnt + 1'b1 : edge_cnt;
  assign busy        = (state_q != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start || continuous) state_d = SETTLE;
      SETTLE:
        if (settle_done) state_d = MEASURE;
      MEASURE:
        if (gate_done)
          state_d = (chan_q == 2'd3) ? DONE : SETTLE;
      DONE:
        state_d = continuous ? SETTLE : IDLE;
    endcase
  end

  // Synchroniser, counters, shadows and published frame
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      chan_q       <= 2'd0;
      s2_s3        <= 2'b00;
      settle_cnt   <= '0;
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      frame_ovf    <= 1'b0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
      freq_red     <= '0;
      freq_green   <= '0;
      freq_blue    <= '0;
      freq_clear   <= '0;
      overflow     <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sync1        <= sensor_out;
      sync2        <= sync1;
      prev         <= sync2;
      sample_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start || continuous) begin
            chan_q     <= 2'd0;
            s2_s3      <= 2'b00;
            settle_cnt <= '0;
            frame_ovf  <= 1'b0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_done) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
          end
        end
        MEASURE: begin
          gate_cnt <= gate_cnt + 1'b1;
          edge_cnt <= cnt_next;
          if (ovf_now) frame_ovf <= 1'b1;
          if (gate_done) begin
            shadow_q[chan_q] <= cnt_next;
            settle_cnt       <= '0;
            if (chan_q != 2'd3) begin
              chan_q <= chan_q + 2'd1;
              s2_s3  <= sel_of(chan_q + 2'd1);
            end else begin
              // last channel bypasses its shadow so the
              // whole frame lands on the same edge
              freq_red     <= shadow_q[0];
              freq_green   <= shadow_q[1];
              freq_blue    <= shadow_q[2];
              freq_clear   <= cnt_next;
              overflow     <= frame_ovf | ovf_now;
              sample_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          chan_q     <= 2'd0;
          s2_s3      <= 2'b00;
          settle_cnt <= '0;
          frame_ovf  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcs_freq_sampler.sv
// Directed bench for tcs_freq_sampler: filter sequencing,
// counts, saturation, continuous mode, reset, glitches.
module tb_tcs_freq_sampler;

  localparam int G = 100;
  localparam int S = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sensor;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [1:0]  s2_s3;
  logic [15:0] fr_r, fr_g, fr_b, fr_c;
  logic        sv, ovf, busy;

  logic        rst_s = 1'b1;
  logic        sensor_s;
  logic        start_s = 1'b0;
  logic        cont_s = 1'b0;
  logic [1:0]  s2_s3_s;
  logic [3:0]  fs_r, fs_g, fs_b, fs_c;
  logic        sv_s, ovf_s, busy_s;

  int total = 0;
  int bad = 0;
  logic alt = 1'b0;
  logic frc = 1'b0;
  logic frc_lvl = 1'b0;
  int hs = 2;

  tcs_freq_sampler #(
    .CNT_W(16), .GATE_CYCLES(G), .SETTLE_CYCLES(S)
  ) u_dut (
    .clk(clk), .rst(rst), .sensor_out(sensor),
    .start(start), .continuous(cont), .s2_s3(s2_s3),
    .freq_red(fr_r), .freq_green(fr_g),
    .freq_blue(fr_b), .freq_clear(fr_c),
    .sample_valid(sv), .overflow(ovf), .busy(busy)
  );

  tcs_freq_sampler #(
    .CNT_W(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S)
  ) u_sat (
    .clk(clk), .rst(rst_s), .sensor_out(sensor_s),
    .start(start_s), .continuous(cont_s), .s2_s3(s2_s3_s),
    .freq_red(fs_r), .freq_green(fs_g),
    .freq_blue(fs_b), .freq_clear(fs_c),
    .sample_valid(sv_s), .overflow(ovf_s), .busy(busy_s)
  );

  function automatic int hp(input logic [1:0] sel,
                            input logic a);
    if (a) return 5;
    case (sel)
      2'b00:   return 5;
      2'b11:   return 10;
      2'b01:   return 25;
      default: return 2;
    endcase
  endfunction

  // Sensor model: phase restarts on every filter/busy change
  initial begin : model_main
    logic [2:0] key;
    int ph;
    logic lvl;
    key = 3'b000; ph = 0; lvl = 1'b0; sensor = 1'b0;
    forever begin
      @(negedge clk); #1;
      if ({busy, s2_s3} != key) begin
        key = {busy, s2_s3}; ph = 0; lvl = 1'b0;
      end else begin
        ph++;
        if (ph >= hp(s2_s3, alt)) begin
          ph = 0; lvl = ~lvl;
        end
      end
      sensor = frc ? frc_lvl : lvl;
    end
  end

  initial begin : model_sat
    logic [2:0] key;
    int ph;
    key = 3'b000; ph = 0; sensor_s = 1'b0;
    forever begin
      @(negedge clk); #1;
      if ({busy_s, s2_s3_s} != key) begin
        key = {busy_s, s2_s3_s}; ph = 0; sensor_s = 1'b0;
      end else begin
        ph++;
        if (ph >= hs) begin
          ph = 0; sensor_s = ~sensor_s;
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, want);
    end
  endtask

  task automatic wait_sv(input bit which, output int n);
    n = 0;
    while ((which ? sv_s : sv) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 1000) else begin
      bad++;
      $error("FAIL wait_valid observed=%0d expected=<1000", n);
    end
  endtask

  task automatic chk_frame(input string tag,
                           input int r, input int g,
                           input int b, input int c,
                           input logic o);
    chk({tag, "_red"}, fr_r, r);
    chk({tag, "_green"}, fr_g, g);
    chk({tag, "_blue"}, fr_b, b);
    chk({tag, "_clear"}, fr_c, c);
    chk({tag, "_ovf"}, ovf, o);
  endtask

  initial begin : main
    int n;
    int pulses;
    logic [1:0] es;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_red", fr_r, 0);
    chk("rst_clear", fr_c, 0);
    chk("rst_s2s3", s2_s3, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", sv, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sat_busy", busy_s, 0);
    rst = 1'b0;
    rst_s = 1'b0;
    repeat (5) @(negedge clk);

    // one frame: sequencing, busy, latency, counts
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 441; k++) begin
      es = (k <= 110) ? 2'b00 : (k <= 220) ? 2'b11 :
           (k <= 330) ? 2'b01 : 2'b10;
      if (k <= 440) chk($sformatf("seq_s2s3_%0d", k), s2_s3, es);
      chk($sformatf("seq_busy_%0d", k), busy, 1);
      chk($sformatf("seq_valid_%0d", k), sv, (k == 441));
      if (k < 441) @(negedge clk);
    end
    chk_frame("f1", 10, 5, 2, 25, 1'b0);
    @(negedge clk);
    chk("idle_s2s3", s2_s3, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", sv, 0);

    // continuous mode with stimulus change between frames
    repeat (3) @(negedge clk);
    cont = 1'b1;
    wait_sv(1'b0, n);
    chk("cont_lat", n, 441);
    chk_frame("c1", 10, 5, 2, 25, 1'b0);
    alt = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sv(1'b0, n);
    chk("cont_gap", n + 2, 441);
    chk_frame("c2", 10, 10, 10, 10, 1'b0);
    cont = 1'b0;
    @(negedge clk);
    chk("cont_stop_busy", busy, 0);
    alt = 1'b0;
    pulses = 0;
    repeat (500) begin
      @(negedge clk);
      if (sv === 1'b1) pulses++;
    end
    chk("cont_no_extra", pulses, 0);
    chk_frame("c2_hold", 10, 10, 10, 10, 1'b0);

    // reset during green MEASURE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (149) @(negedge clk);
    chk("pre_rst_s2s3", s2_s3, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_frame("mrst", 0, 0, 0, 0, 1'b0);
    chk("mrst_s2s3", s2_s3, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", sv, 0);
    pulses = 0;
    repeat (450) begin
      @(negedge clk);
      if (sv === 1'b1) pulses++;
    end
    chk("mrst_no_valid", pulses, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sv(1'b0, n);
    chk("mrst_lat", n, 440);
    chk_frame("f2", 10, 5, 2, 25, 1'b0);

    // glitch: one 1-cycle pulse in red window
    frc = 1'b1;
    frc_lvl = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    frc_lvl = 1'b1;
    @(negedge clk);
    frc_lvl = 1'b0;
    wait_sv(1'b0, n);
    chk("glitch_red_le1", (fr_r <= 16'd1), 1);
    chk("glitch_green", fr_g, 0);
    chk("glitch_blue", fr_b, 0);
    chk("glitch_clear", fr_c, 0);

    // constant high input
    frc_lvl = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sv(1'b0, n);
    chk_frame("high", 0, 0, 0, 0, 1'b0);
    frc = 1'b0;

    // saturation on the 4-bit instance, then recovery
    hs = 2;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_sv(1'b1, n);
    chk("sat_lat", n, 440);
    chk("sat_red", fs_r, 15);
    chk("sat_green", fs_g, 15);
    chk("sat_blue", fs_b, 15);
    chk("sat_clear", fs_c, 15);
    chk("sat_ovf", ovf_s, 1);
    hs = 25;
    repeat (3) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_sv(1'b1, n);
    chk("rec_red", fs_r, 2);
    chk("rec_green", fs_g, 2);
    chk("rec_blue", fs_b, 2);
    chk("rec_clear", fs_c, 2);
    chk("rec_ovf", ovf_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
